act_relu_pipe: RTL and testbench
================================

Name: act_relu_pipe

Overview:
- Parametrised successor to the fixed 32-lane ReLU stage.
- Applies a selectable element-wise activation to a vector of N signed fixed-point lanes: bypass, ReLU, leaky ReLU or clipped ReLU.
- Uses a 2-stage pipeline with full valid/ready backpressure and emits a per-vector zero count for sparsity monitoring.
- Sits between a conv/dense accumulator output and the next layer's input buffer.

Parameters:
- N, 32, number of lanes per vector (1..64)
- W, 16, lane width in bits (signed, Q4.12 when W=16)
- LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT (1..W-1)
- CLIP_VAL, 16'sh6000, clipped-ReLU ceiling (6.0 in Q4.12); must be >0 and representable in W bits
- ZC_W, $clog2(N+1), width of the zero-count field

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  upstream vector valid
- ready_out  out  1  block can accept a vector this cycle
- mode_in  in  2  activation select, sampled with the vector: 0 bypass, 1 ReLU, 2 leaky, 3 clip
- input_data  in  N x W signed  input vector
- valid_out  out  1  output vector valid
- ready_in  in  1  downstream can accept
- output_data  out  N x W signed  activated vector
- zero_count  out  ZC_W  number of lanes in output_data equal to 0

Behaviour:
- Reset (reset=0, asynchronous): stage valids cleared; valid_out=0; output_data all 0; zero_count=0; ready_out=1 as soon as reset deasserts.
- Transfer in: valid_in & ready_out. Transfer out: valid_out & ready_in.
- Stage 1 registers input_data and mode_in. Stage 2 registers the activated result and zero_count. Latency is 2 cycles from transfer-in to valid_out with no stall. Throughput is 1 vector per cycle.
- Advance rules:
  - s2_en = !s2_valid | ready_in
  - s1_en = !s1_valid | s2_en
  - ready_out = s1_en
- The combinational path ready_in -> ready_out is accepted.
- Under stall, output_data, zero_count and valid_out are held stable. No vector is dropped or duplicated.
- A held vector keeps the mode sampled at its own transfer-in. A mode change between vectors takes effect per vector, never mid-vector.
- Arithmetic per lane x:
  - mode 0: y = x
  - mode 1: y = (x<0) ? 0 : x
  - mode 2: y = (x<0) ? (x >>> LEAK_SHIFT) : x. Arithmetic shift with floor rounding, so -1 stays -1.
  - mode 3: y = (x<0) ? 0 : ((x > CLIP_VAL) ? CLIP_VAL : x)
- All results fit in W bits; there is no overflow path.
- zero_count is computed in stage 2 from the y values: popcount of (y==0). Range 0..N.
- Simultaneous transfer-in and transfer-out in the same cycle is legal at full occupancy; the pipeline shifts.
- Reset mid-operation flushes both stages immediately. In-flight vectors are discarded.
- valid_out must not depend combinationally on valid_in.

Decomposition:
- Shared package act_pkg holds:
  - enum act_mode_t {ACT_BYPASS=0, ACT_RELU=1, ACT_LEAKY=2, ACT_CLIP=3}
  - Q4.12 constant Q412_SIX = 16'sh6000
- One sub-module, act_lane: purely combinational, one lane, inputs x and mode, output y. The top instantiates N of these in a generate loop. The zero-count adder tree stays in the top.

Test Plan:
- Reset and idle. Hold reset=0 for 3 cycles, then release. Required: valid_out=0, output_data all 0, zero_count=0, ready_out=1.
- Mode 1, ready_in=1, lanes = {0x1000, 0xF000, 0x0000, 0x7FFF, rest 0x8000}. Required 2 cycles later: {0x1000, 0, 0, 0x7FFF, 0...}, zero_count = N-2.
- Mode 2 (LEAK_SHIFT=3), lanes {0xF000, 0xFFFF, 0x0800}. Required: {0xFE00, 0xFFFF, 0x0800}, with zero_count counting only literal zeros.
- Mode 3, lanes {0x7000, 0x6000, 0x5FFF, 0xC000}. Required: {0x6000, 0x6000, 0x5FFF, 0x0000}.
- Backpressure. Stream 5 back-to-back vectors with alternating modes while ready_in toggles in the pattern 1,0,0,1,0,1,1... Required:
  - ready_out deasserts once both stages are full.
  - Outputs stay stable while stalled.
  - All 5 vectors emerge in order, each using its own mode.
- Reset mid-stream. Assert reset while 2 vectors are in flight. Required: valid_out drops asynchronously and neither vector appears after reset release.

Source files
------------

// File: rtl/act_pkg.sv
// Shared activation-mode encoding and fixed-point constants for the activation pipeline.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLIP   = 2'd3
  } act_mode_t;

  localparam logic signed [15:0] Q412_SIX = 16'sh6000;

endpackage

// File: rtl/act_lane.sv
// Single-lane activation, purely combinational (zero latency, no flow control).
// Negative detection uses the sign bit directly; leaky uses an arithmetic shift (floor).
module act_lane
  import act_pkg::*;
#(
  parameter int                     W          = 16,
  parameter int                     LEAK_SHIFT = 3,
  parameter logic signed [W-1:0]    CLIP_VAL   = Q412_SIX
) (
  input  logic [W-1:0] x,
  input  logic [1:0]   mode,
  output logic [W-1:0] y
);

  logic signed [W-1:0] w_x;
  logic                w_neg;

  assign w_x   = x;
  assign w_neg = w_x[W-1];

  always_comb begin
    y = x;
    case (act_mode_t'(mode))
      ACT_RELU:  if (w_neg) y = '0;
      ACT_LEAKY: if (w_neg) y = w_x >>> LEAK_SHIFT;
      ACT_CLIP: begin
        if (w_neg)                y = '0;
        else if (w_x > CLIP_VAL)  y = CLIP_VAL;
      end
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/act_relu_pipe.sv
// N-lane activation stage with per-vector zero count; 2-cycle latency, 1 vector/cycle.
// Full valid/ready backpressure: outputs hold under stall, ready_out follows ready_in combinationally.
module act_relu_pipe
  import act_pkg::*;
#(
  parameter int                  N          = 32,
  parameter int                  W          = 16,
  parameter int                  LEAK_SHIFT = 3,
  parameter logic signed [W-1:0] CLIP_VAL   = Q412_SIX,
  parameter int                  ZC_W       = $clog2(N+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [1:0]        mode_in,
  input  logic [N*W-1:0]    input_data,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [N*W-1:0]    output_data,
  output logic [ZC_W-1:0]   zero_count
);

  logic              r_s1_valid;
  logic [1:0]        r_s1_mode;
  logic [N*W-1:0]    r_s1_data;
  logic              r_s2_valid;
  logic [N*W-1:0]    r_s2_data;
  logic [ZC_W-1:0]   r_s2_zc;

  logic              w_s1_en;
  logic              w_s2_en;
  logic [N*W-1:0]    w_y;
  logic [ZC_W-1:0]   w_zc;

  assign w_s2_en   = !r_s2_valid || ready_in;
  assign w_s1_en   = !r_s1_valid || w_s2_en;
  assign ready_out = w_s1_en;

  // Lanes see the mode captured with the vector, so a held vector keeps its own mode.
  for (genvar g = 0; g < N; g++) begin : g_lane
    act_lane #(
      .W          (W),
      .LEAK_SHIFT (LEAK_SHIFT),
      .CLIP_VAL   (CLIP_VAL)
    ) u_lane (
      .x    (r_s1_data[g*W +: W]),
      .mode (r_s1_mode),
      .y    (w_y[g*W +: W])
    );
  end

  always_comb begin
    w_zc = '0;
    for (int i = 0; i < N; i++) begin
      w_zc = w_zc + ZC_W'(w_y[i*W +: W] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= '0;
      r_s1_data  <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= valid_in;
      if (valid_in) begin
        r_s1_data <= input_data;
        r_s1_mode <= mode_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_zc    <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_y;
        r_s2_zc   <= w_zc;
      end
    end
  end

  assign valid_out   = r_s2_valid;
  assign output_data = r_s2_data;
  assign zero_count  = r_s2_zc;

endmodule

// File: tb/tb_act_relu_pipe.sv
// Scoreboard bench for act_relu_pipe: directed lane patterns, backpressure streams, mid-stream reset.
module tb_act_relu_pipe;

  localparam int N    = 32;
  localparam int W    = 16;
  localparam int ZC_W = $clog2(N+1);
  localparam int LS   = 3;
  localparam logic signed [W-1:0] CLIPV = 16'sh6000;

  typedef logic [N*W-1:0] vec_t;
  typedef struct {
    vec_t d;
    int   zc;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_in;
  logic            ready_out;
  logic [1:0]      mode_in;
  vec_t            input_data;
  logic            valid_out;
  logic            ready_in;
  vec_t            output_data;
  logic [ZC_W-1:0] zero_count;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  bit   saw_stall = 0;
  bit   src_done  = 0;

  act_relu_pipe #(.N(N), .W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .mode_in     (mode_in),
    .input_data  (input_data),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .output_data (output_data),
    .zero_count  (zero_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input vec_t got, input vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_model(input logic [W-1:0] x, input logic [1:0] m);
    logic signed [W-1:0] s;
    logic [W-1:0]        y;
    s = x;
    y = x;
    case (m)
      2'd1: if (s[W-1]) y = '0;
      2'd2: if (s[W-1]) y = s >>> LS;
      2'd3: begin
        if (s[W-1])         y = '0;
        else if (s > CLIPV) y = CLIPV;
      end
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic exp_t model(input vec_t d, input logic [1:0] m);
    exp_t e;
    logic [W-1:0] y;
    e.d  = '0;
    e.zc = 0;
    for (int i = 0; i < N; i++) begin
      y = lane_model(d[i*W +: W], m);
      e.d[i*W +: W] = y;
      if (y == '0) e.zc++;
    end
    return e;
  endfunction

  function automatic vec_t vec(input logic [W-1:0] l0, l1, l2, l3, fill);
    vec_t v;
    for (int i = 0; i < N; i++) v[i*W +: W] = fill;
    v[0*W +: W] = l0;
    v[1*W +: W] = l1;
    v[2*W +: W] = l2;
    v[3*W +: W] = l3;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) begin
      v[i*W +: W] = W'($urandom);
      if ($urandom_range(0, 5) == 0) v[i*W +: W] = '0;
    end
    return v;
  endfunction

  // Scoreboard: queue holds vectors currently inside the pipeline.
  always @(negedge clk) begin
    if (reset) begin
      chk("ready_out", ready_out, (q.size() < 2) || ready_in);
      if (!ready_out) saw_stall = 1;
      if (valid_out) begin
        if (q.size() == 0) begin
          chk("spurious_vld", valid_out, 0);
        end else begin
          chk("out_data", output_data, q[0].d);
          chk("zero_count", zero_count, q[0].zc);
          if (ready_in) void'(q.pop_front());
        end
      end
      if (valid_in && ready_out) q.push_back(model(input_data, mode_in));
    end
  end

  task automatic send1(input logic [1:0] m, input vec_t d);
    @(posedge clk); #1;
    ready_in = 1; valid_in = 1; mode_in = m; input_data = d;
    @(posedge clk); #1;
    valid_in = 0; mode_in = ~m; input_data = '1;
    @(negedge clk);
    chk("lat_s1", valid_out, 0);
    @(negedge clk);
    chk("lat_s2", valid_out, 1);
  endtask

  task automatic stream(input int nvec, input bit rand_rdy);
    logic rp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    src_done = 0;
    fork
      begin
        int k = 0;
        while (!src_done && k < 2000) begin
          if (rand_rdy)   ready_in = ($urandom_range(0, 3) != 0);
          else if (k < 7) ready_in = rp[k];
          else            ready_in = 1;
          k++;
          @(posedge clk); #1;
        end
      end
      begin
        for (int v = 0; v < nvec; v++) begin
          int w = 0;
          valid_in   = 1;
          mode_in    = rand_rdy ? 2'($urandom_range(0, 3)) : ((v % 2) ? 2'd2 : 2'd3);
          input_data = rand_vec();
          forever begin
            @(negedge clk);
            if (ready_out) break;
            w++;
            if (w > 50) begin
              chk("accept_timeout", 1, 0);
              break;
            end
          end
          @(posedge clk); #1;
        end
        valid_in = 0;
        src_done = 1;
      end
    join
  endtask

  task automatic drain();
    int w = 0;
    ready_in = 1;
    while (q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    reset = 0; valid_in = 0; ready_in = 0; mode_in = 0; input_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data", output_data, 0);
    chk("rst_zc", zero_count, 0);
    chk("rst_ready_out", ready_out, 1);

    send1(2'd1, vec(16'h1000, 16'hF000, 16'h0000, 16'h7FFF, 16'h8000));
    send1(2'd2, vec(16'hF000, 16'hFFFF, 16'h0800, 16'h0000, 16'h0000));
    send1(2'd3, vec(16'h7000, 16'h6000, 16'h5FFF, 16'hC000, 16'h0001));
    send1(2'd0, vec(16'h8000, 16'hFFFF, 16'h0000, 16'h1234, 16'h0000));
    send1(2'd2, vec(16'h8000, 16'hFFF8, 16'hFFF9, 16'h7FFF, 16'hFFF0));
    drain();

    saw_stall = 0;
    stream(5, 0);
    drain();
    chk("bp_stall_seen", saw_stall, 1);

    // Two vectors held inside, then reset while stalled.
    @(posedge clk); #1;
    ready_in = 0; valid_in = 1; mode_in = 2'd1; input_data = rand_vec();
    @(posedge clk); #1;
    mode_in = 2'd2; input_data = rand_vec();
    @(posedge clk); #1;
    valid_in = 0;
    @(negedge clk);
    chk("pre_rst_vld", valid_out, 1);
    #2 reset = 0;
    q.delete();
    #1;
    chk("rst_async_vld", valid_out, 0);
    chk("rst_async_data", output_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1; ready_in = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_flush_vld", valid_out, 0);
    end

    stream(40, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
